// File: rtl/harvard_bus_bridge.sv
// Serialises the Harvard CPU's instruction fetch and optional data access onto one
// waitrequest bus, then pulses clk_enable for one cycle to advance the CPU.
module harvard_bus_bridge #(
  parameter int unsigned MAX_WAIT    = 16,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_active,
  output logic                   clk_enable,
  input  logic [31:0]            instr_address,
  output logic [31:0]            instr_readdata,
  input  logic [31:0]            data_address,
  input  logic                   data_read,
  input  logic                   data_write,
  input  logic [31:0]            data_writedata,
  output logic [31:0]            data_readdata,
  output logic [31:0]            bus_address,
  output logic                   bus_read,
  output logic                   bus_write,
  output logic [3:0]             bus_byteenable,
  output logic [31:0]            bus_writedata,
  input  logic                   bus_waitrequest,
  input  logic [31:0]            bus_readdata,
  output logic                   bus_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    DATA,
    COMMIT,
    HALTED
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              strobe;
  logic              done;
  logic              timeout;
  logic              mem_op;

  assign bus_byteenable = 4'hF;
  assign mem_op         = data_read | data_write;
  assign strobe         = bus_read | bus_write;
  assign done           = strobe & ~bus_waitrequest;
  assign timeout        = strobe & bus_waitrequest & (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Bus outputs are decoded from state; the CPU is frozen while clk_enable is low,
  // so its address/data inputs (and hence the bus) stay stable through waitrequest.
  always_comb begin
    state_nxt     = state;
    clk_enable    = 1'b0;
    bus_read      = 1'b0;
    bus_write     = 1'b0;
    bus_address   = '0;
    bus_writedata = '0;
    case (state)
      FETCH: begin
        bus_read    = 1'b1;
        bus_address = instr_address;
      end
      DATA: begin
        bus_address = data_address;
        if (data_write) begin
          bus_write     = 1'b1;
          bus_writedata = data_writedata;
        end else begin
          bus_read = 1'b1;
        end
      end
      COMMIT: clk_enable = 1'b1;
      default: ;
    endcase
    // Strobes are masked while reset is held so an aborted access drops at once.
    if (!reset) begin
      clk_enable    = 1'b0;
      bus_read      = 1'b0;
      bus_write     = 1'b0;
      bus_address   = '0;
      bus_writedata = '0;
    end
    case (state)
      FETCH:   if (timeout) state_nxt = HALTED; else if (done) state_nxt = DECODE;
      DECODE:  state_nxt = mem_op ? DATA : COMMIT;
      DATA:    if (timeout) state_nxt = HALTED; else if (done) state_nxt = COMMIT;
      COMMIT:  state_nxt = cpu_active ? FETCH : HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= FETCH;
      wait_cnt       <= '0;
      bus_error      <= 1'b0;
      stall_cycles   <= '0;
      instr_readdata <= '0;
      data_readdata  <= '0;
    end else begin
      state <= state_nxt;
      if (strobe) begin
        if (!bus_waitrequest || timeout) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout) bus_error <= 1'b1;
      if (state == FETCH && done) instr_readdata <= bus_readdata;
      if (state == DATA && bus_read && done) data_readdata <= bus_readdata;
      if (state != HALTED && !clk_enable && stall_cycles != '1)
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_harvard_bus_bridge.sv
// Directed bench for harvard_bus_bridge: ALU stream, load with waits, store,
// timeout, halt and reset mid-access.
module tb_harvard_bus_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_active;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        bus_error;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_bad    = 0;
  int wr_done;

  harvard_bus_bridge #(.MAX_WAIT(16), .STALL_CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_active     (cpu_active),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .bus_address    (bus_address),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_byteenable (bus_byteenable),
    .bus_writedata  (bus_writedata),
    .bus_waitrequest(bus_waitrequest),
    .bus_readdata   (bus_readdata),
    .bus_error      (bus_error),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Leaves reset low just after a clock edge; caller sets inputs then releases.
  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cpu_active = 1'b1;
    instr_address = '0; data_address = '0; data_read = 1'b0; data_write = 1'b0;
    data_writedata = '0; bus_waitrequest = 1'b0; bus_readdata = '0;

    // 1: zero-wait ALU stream
    apply_reset();
    check("rst_clk_enable", 32'(clk_enable), 32'd0);
    check("rst_bus_read", 32'(bus_read), 32'd0);
    check("rst_bus_write", 32'(bus_write), 32'd0);
    check("rst_bus_address", bus_address, 32'h0);
    check("rst_instr_readdata", instr_readdata, 32'h0);
    check("rst_data_readdata", data_readdata, 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    check("byteenable", 32'(bus_byteenable), 32'hF);
    instr_address = 32'hBFC0_0000;
    bus_readdata  = 32'h0128_4020;
    reset = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("alu_clk_enable_c%0d", c), 32'(clk_enable), 32'((c % 3) == 0));
      check($sformatf("alu_bus_read_c%0d", c), 32'(bus_read), 32'((c % 3) == 1));
      if (c == 1) check("alu_fetch_addr", bus_address, 32'hBFC0_0000);
      next_cycle();
    end
    check("alu_stall", stall_cycles, 32'd6);
    check("alu_instr_readdata", instr_readdata, 32'h0128_4020);

    // 2: load with two wait states in DATA
    apply_reset();
    instr_address = 32'hBFC0_0000; data_address = 32'h0000_0004;
    data_read = 1'b1; data_write = 1'b0;
    reset = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      bus_waitrequest = (c == 3 || c == 4);
      bus_readdata    = (c == 1) ? 32'h8C02_0004 : 32'hDEAD_BEEF;
      @(negedge clk);
      check($sformatf("lw_clk_enable_c%0d", c), 32'(clk_enable), 32'(c == 6));
      if (c == 1) check("lw_fetch_addr", bus_address, 32'hBFC0_0000);
      if (c == 2) check("lw_decode_read", 32'(bus_read), 32'd0);
      if (c >= 3 && c <= 5) begin
        check($sformatf("lw_data_read_c%0d", c), 32'(bus_read), 32'd1);
        check($sformatf("lw_data_addr_c%0d", c), bus_address, 32'h0000_0004);
        check($sformatf("lw_data_write_c%0d", c), 32'(bus_write), 32'd0);
      end
      if (c == 6) begin
        check("lw_data_readdata", data_readdata, 32'hDEAD_BEEF);
        check("lw_instr_readdata", instr_readdata, 32'h8C02_0004);
      end
      next_cycle();
    end

    // 3: store (read also raised; write must win), one wait state
    apply_reset();
    bus_waitrequest = 1'b0;
    instr_address = 32'hBFC0_0010; data_address = 32'h0000_0010;
    data_read = 1'b1; data_write = 1'b1; data_writedata = 32'h1234_5678;
    bus_readdata = 32'hAC02_0010;
    reset = 1'b1;
    wr_done = 0;
    for (int c = 1; c <= 5; c++) begin
      bus_waitrequest = (c == 3);
      @(negedge clk);
      if (bus_write && !bus_waitrequest) wr_done++;
      if (c >= 3 && c <= 4) begin
        check($sformatf("sw_write_c%0d", c), 32'(bus_write), 32'd1);
        check($sformatf("sw_read_c%0d", c), 32'(bus_read), 32'd0);
        check($sformatf("sw_wdata_c%0d", c), bus_writedata, 32'h1234_5678);
        check($sformatf("sw_addr_c%0d", c), bus_address, 32'h0000_0010);
      end
      check($sformatf("sw_clk_enable_c%0d", c), 32'(clk_enable), 32'(c == 5));
      next_cycle();
    end
    check("sw_write_count", 32'(wr_done), 32'd1);
    data_read = 1'b0; data_write = 1'b0;

    // 4: waitrequest stuck high in FETCH
    apply_reset();
    bus_waitrequest = 1'b1;
    reset = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1 || c == 16) begin
        check($sformatf("to_read_c%0d", c), 32'(bus_read), 32'd1);
        check($sformatf("to_error_c%0d", c), 32'(bus_error), 32'd0);
      end
      next_cycle();
    end
    check("to_error_set", 32'(bus_error), 32'd1);
    check("to_read_dropped", 32'(bus_read), 32'd0);
    check("to_stall", stall_cycles, 32'd16);
    bus_waitrequest = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("to_halt_ce_%0d", c), 32'(clk_enable), 32'd0);
      check($sformatf("to_halt_read_%0d", c), 32'(bus_read), 32'd0);
      next_cycle();
    end
    check("to_error_sticky", 32'(bus_error), 32'd1);
    check("to_stall_frozen", stall_cycles, 32'd16);

    // 5: halt at first COMMIT (cpu_active ignored before it)
    apply_reset();
    cpu_active = 1'b0;
    reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("halt_read_c%0d", c), 32'(bus_read), 32'(c == 1));
      check($sformatf("halt_ce_c%0d", c), 32'(clk_enable), 32'(c == 3));
      next_cycle();
    end
    check("halt_stall", stall_cycles, 32'd2);
    cpu_active = 1'b1;

    // 6: reset while a DATA read is waiting
    apply_reset();
    instr_address = 32'hBFC0_0000; data_address = 32'h0000_0004;
    data_read = 1'b1; data_write = 1'b0;
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      bus_waitrequest = (c == 3);
      bus_readdata    = (c == 1) ? 32'h8C02_0004 : 32'h5555_AAAA;
      @(negedge clk);
      if (c == 3) begin
        check("mid_data_read", 32'(bus_read), 32'd1);
        check("mid_data_addr", bus_address, 32'h0000_0004);
      end
      next_cycle();
    end
    reset = 1'b0;
    next_cycle();
    check("mid_rst_read", 32'(bus_read), 32'd0);
    check("mid_rst_addr", bus_address, 32'h0);
    check("mid_rst_instr", instr_readdata, 32'h0);
    check("mid_rst_data", data_readdata, 32'h0);
    check("mid_rst_stall", stall_cycles, 32'd0);
    check("mid_rst_ce", 32'(clk_enable), 32'd0);
    instr_address = 32'hBFC0_0100; bus_waitrequest = 1'b0; data_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("restart_read", 32'(bus_read), 32'd1);
    check("restart_addr", bus_address, 32'hBFC0_0100);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
